// File: rtl/hi_iso14443a_fe.sv
// ISO14443A HF front-end: carrier/load-modulation drive and ADC pause/subcarrier demodulation over SSP.
// Optional HI14A_DEBUG_EN routes ssp_din to dbg (otherwise dbg mirrors ssp_frame).
module hi_iso14443a_fe #(
  parameter logic [7:0]  PAUSE_THRESH = 8'd16,
  parameter int unsigned PAUSE_LEN    = 4,
  parameter logic [7:0]  SUBC_THRESH  = 8'd40
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic       ck_1356megb,
  input  logic       pck0,
  input  logic       cross_hi,
  input  logic       cross_lo,
  input  logic [7:0] adc_d,
  input  logic [2:0] mod_type,
  input  logic       ssp_dout,
  output logic       adc_clk,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  output logic       pwr_lo,
  output logic       pwr_hi,
  output logic       pwr_oe1,
  output logic       pwr_oe2,
  output logic       pwr_oe3,
  output logic       pwr_oe4,
  output logic       dbg
);

  localparam int unsigned      RUN_W   = $clog2(PAUSE_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PAUSE_LEN);

  typedef enum logic [2:0] {
    SNIFFER       = 3'd0,
    TAGSIM_LISTEN = 3'd1,
    TAGSIM_MOD    = 3'd2,
    READER_LISTEN = 3'd3,
    READER_MOD    = 3'd4,
    TAGSIM_MOD2   = 3'd5
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [3:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             frame_q, frame_d;
  logic             din_q, din_d;
  logic             mod_bit_q, mod_bit_d;
  logic [RUN_W-1:0] run_q, run_d, run_nx;
  logic             pause_q, pause_d, pause_nx;
  logic [7:0]       max_q, max_d, max_nx;
  logic [7:0]       min_q, min_d, min_nx;
  logic             period_end, result, subc;
  logic             unused_in;

  assign unused_in = ^{pck0, cross_hi, cross_lo};

  always_comb begin
    mode_d = SNIFFER;
    case (mod_type)
      3'd1:    mode_d = TAGSIM_LISTEN;
      3'd2:    mode_d = TAGSIM_MOD;
      3'd3:    mode_d = READER_LISTEN;
      3'd4:    mode_d = READER_MOD;
      3'd5:    mode_d = TAGSIM_MOD2;
      default: mode_d = SNIFFER;
    endcase
  end

  // Detector "next" values fold in the current sample so the clock at
  // clk_cnt==15 still contributes to the result latched at the period end.
  always_comb begin
    run_nx = '0;
    if (adc_d < PAUSE_THRESH)
      run_nx = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
    pause_nx = pause_q | (run_nx == RUN_MAX);
    max_nx   = (adc_d > max_q) ? adc_d : max_q;
    min_nx   = (adc_d < min_q) ? adc_d : min_q;

    case (mode_q)
      SNIFFER, TAGSIM_LISTEN: result = pause_nx;
      READER_LISTEN:          result = (max_nx - min_nx) > SUBC_THRESH;
      default:                result = 1'b0;
    endcase

    period_end = (clk_cnt_q == 4'd15);
    clk_cnt_d  = clk_cnt_q + 4'd1;
    bit_cnt_d  = period_end ? bit_cnt_q + 3'd1 : bit_cnt_q;
    frame_d    = (bit_cnt_d == 3'd0);
    mod_bit_d  = (clk_cnt_q == 4'd7) ? ssp_dout : mod_bit_q;

    if (period_end) begin
      din_d   = result;
      run_d   = '0;
      pause_d = 1'b0;
      max_d   = '0;
      min_d   = '1;
    end else begin
      din_d   = din_q;
      run_d   = run_nx;
      pause_d = pause_nx;
      max_d   = max_nx;
      min_d   = min_nx;
    end
  end

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= SNIFFER;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      frame_q   <= 1'b0;
      din_q     <= 1'b0;
      mod_bit_q <= 1'b0;
      run_q     <= '0;
      pause_q   <= 1'b0;
      max_q     <= '0;
      min_q     <= '1;
    end else begin
      mode_q    <= mode_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      din_q     <= din_d;
      mod_bit_q <= mod_bit_d;
      run_q     <= run_d;
      pause_q   <= pause_d;
      max_q     <= max_d;
      min_q     <= min_d;
    end
  end

  assign subc = clk_cnt_q[1];

  always_comb begin
    pwr_oe4 = 1'b0;
    pwr_hi  = 1'b0;
    case (mode_q)
      TAGSIM_MOD:    pwr_oe4 = mod_bit_q & subc;
      TAGSIM_MOD2:   pwr_oe4 = subc & (mod_bit_q ? ~clk_cnt_q[3] : clk_cnt_q[3]);
      READER_MOD:    pwr_hi  = ck_1356megb & ~mod_bit_q;
      READER_LISTEN: pwr_hi  = ck_1356megb;
      default:       ;
    endcase
  end

  assign adc_clk   = ck_1356meg;
  assign ssp_clk   = clk_cnt_q[3];
  assign ssp_frame = frame_q;
  assign ssp_din   = din_q;
  assign pwr_lo    = 1'b0;
  assign pwr_oe1   = 1'b0;
  assign pwr_oe2   = 1'b0;
  assign pwr_oe3   = 1'b0;

`ifdef HI14A_DEBUG_EN
  assign dbg = din_q;
`else
  assign dbg = frame_q;
`endif

endmodule

// File: tb/tb_hi_iso14443a_fe.sv
// Directed testbench for hi_iso14443a_fe; "n" counts falling edges since reset release (state after n rising edges).
module tb_hi_iso14443a_fe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ckb;
  logic       pck0 = 1'b0;
  logic       cross_hi = 1'b0;
  logic       cross_lo = 1'b0;
  logic [7:0] adc;
  logic [2:0] mode;
  logic       dout;
  logic       adc_clk, ssp_clk, ssp_frame, ssp_din, pwr_lo, pwr_hi;
  logic       pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg;

  int n_cmp = 0;
  int n_bad = 0;

  hi_iso14443a_fe #(
    .PAUSE_THRESH(8'd16),
    .PAUSE_LEN   (4),
    .SUBC_THRESH (8'd40)
  ) dut (
    .ck_1356meg (clk),
    .rst_n      (rst_n),
    .ck_1356megb(ckb),
    .pck0       (pck0),
    .cross_hi   (cross_hi),
    .cross_lo   (cross_lo),
    .adc_d      (adc),
    .mod_type   (mode),
    .ssp_dout   (dout),
    .adc_clk    (adc_clk),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .pwr_lo     (pwr_lo),
    .pwr_hi     (pwr_hi),
    .pwr_oe1    (pwr_oe1),
    .pwr_oe2    (pwr_oe2),
    .pwr_oe3    (pwr_oe3),
    .pwr_oe4    (pwr_oe4),
    .dbg        (dbg)
  );

  always #5 clk = ~clk;

  // Leaves the bench at falling edge n=0 with reset just released.
  task automatic do_reset(input logic [2:0] m);
    rst_n = 1'b0;
    mode  = m;
    adc   = 8'd200;
    dout  = 1'b0;
    ckb   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3'd1);
    n_cmp++;
    if ({ssp_clk, ssp_frame, ssp_din, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 0000000000",
               {ssp_clk, ssp_frame, ssp_din, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (adc_clk !== 1'b1) begin n_bad++; $display("FAIL adc_clk_high: got %b required 1", adc_clk); end
    @(negedge clk); #1;
    n_cmp++;
    if (adc_clk !== 1'b0) begin n_bad++; $display("FAIL adc_clk_low: got %b required 0", adc_clk); end
  endtask

  task automatic test_clocking();
    int clk_err, frame_err, din_err, dbg_err, frame_hi, rises;
    logic e_clk, e_frame, e_dbg, prev_clk;
    clk_err = 0; frame_err = 0; din_err = 0; dbg_err = 0; frame_hi = 0; rises = 0;
    prev_clk = 1'b0;
    do_reset(3'd1);
    for (int n = 0; n <= 256; n++) begin
      e_clk   = (n % 16) >= 8;
      e_frame = (n >= 1) && ((n / 16) % 8 == 0);
`ifdef HI14A_DEBUG_EN
      e_dbg = 1'b0;
`else
      e_dbg = e_frame;
`endif
      if (ssp_clk !== e_clk)     clk_err++;
      if (ssp_frame !== e_frame) frame_err++;
      if (ssp_din !== 1'b0)      din_err++;
      if (dbg !== e_dbg)         dbg_err++;
      if (n >= 129) begin
        if (ssp_frame === 1'b1) frame_hi++;
        if (ssp_clk === 1'b1 && prev_clk === 1'b0) rises++;
      end
      prev_clk = ssp_clk;
      @(negedge clk);
    end
    n_cmp++; if (clk_err != 0)   begin n_bad++; $display("FAIL ssp_clk_wave: %0d wrong clocks, required 0", clk_err); end
    n_cmp++; if (frame_err != 0) begin n_bad++; $display("FAIL ssp_frame_wave: %0d wrong clocks, required 0", frame_err); end
    n_cmp++; if (frame_hi != 16) begin n_bad++; $display("FAIL frame_high_count: got %0d required 16", frame_hi); end
    n_cmp++; if (rises != 8)     begin n_bad++; $display("FAIL ssp_clk_rises: got %0d required 8", rises); end
    n_cmp++; if (din_err != 0)   begin n_bad++; $display("FAIL idle_din: %0d clocks nonzero, required 0", din_err); end
    n_cmp++; if (dbg_err != 0)   begin n_bad++; $display("FAIL dbg_wave: %0d wrong clocks, required 0", dbg_err); end
  endtask

  // Low samples in bit 3 come back as ssp_din during bit 4; the MCU byte is
  // assembled one bit late so it lines up with the frame that was sampled.
  task automatic run_pause(input logic [2:0] m, input int start, input int len,
                           input logic [7:0] lowv, input logic exp);
    int din_err;
    logic [7:0] byte_v, e_byte;
    logic e;
    din_err = 0; byte_v = '0;
    e_byte = exp ? 8'h10 : 8'h00;
    do_reset(m);
    for (int n = 0; n < 160; n++) begin
      e = exp && (n >= 64) && (n < 80);
      if (ssp_din !== e) din_err++;
      if ((n % 16 == 8) && (n >= 24) && (n <= 136)) byte_v = {byte_v[6:0], ssp_din};
      adc = ((n >= start) && (n < start + len)) ? lowv : 8'd200;
      @(negedge clk);
    end
    n_cmp++;
    if (din_err != 0) begin
      n_bad++;
      $display("FAIL pause_din m=%0d start=%0d len=%0d low=%0d: %0d wrong clocks, required 0", m, start, len, lowv, din_err);
    end
    n_cmp++;
    if (byte_v !== e_byte) begin
      n_bad++;
      $display("FAIL pause_byte m=%0d start=%0d len=%0d low=%0d: got %h required %h", m, start, len, lowv, byte_v, e_byte);
    end
  endtask

  task automatic test_pause_detect();
    run_pause(3'd1, 53, 4,  8'd0,  1'b1);
    run_pause(3'd1, 53, 3,  8'd0,  1'b0);
    run_pause(3'd1, 60, 4,  8'd0,  1'b1);
    run_pause(3'd1, 62, 4,  8'd0,  1'b0);
    run_pause(3'd1, 48, 16, 8'd0,  1'b1);
    run_pause(3'd1, 53, 4,  8'd15, 1'b1);
    run_pause(3'd1, 53, 4,  8'd16, 1'b0);
    run_pause(3'd0, 53, 4,  8'd0,  1'b1);
    run_pause(3'd6, 53, 4,  8'd0,  1'b1);
    run_pause(3'd3, 48, 16, 8'd0,  1'b0);
  endtask

  // bits is sent MSB-first, one bit per ssp_clk period, changing after each fall.
  task automatic run_mod(input logic [2:0] m, input logic [7:0] bits);
    int oe4_err, hi_err, c;
    logic mb, sub, e_oe4, e_hi;
    logic cur[0:8];
    oe4_err = 0; hi_err = 0;
    for (int b = 0; b < 8; b++) cur[b] = bits[7 - b];
    cur[8] = 1'b0;
    do_reset(m);
    for (int n = 0; n < 144; n++) begin
      c   = n % 16;
      sub = ((c / 2) % 2) == 1;
      if (c >= 8)      mb = cur[n / 16];
      else if (n < 16) mb = 1'b0;
      else             mb = cur[n / 16 - 1];
      e_oe4 = 1'b0; e_hi = 1'b0;
      if (m == 3'd2) e_oe4 = mb & sub;
      if (m == 3'd5) e_oe4 = sub & (mb ? (c < 8) : (c >= 8));
      if (m == 3'd4) e_hi  = ckb & ~mb;
      if (m == 3'd3) e_hi  = ckb;
      if (pwr_oe4 !== e_oe4) oe4_err++;
      if (pwr_hi !== e_hi)   hi_err++;
      if (c == 0) dout = cur[n / 16];
      ckb = (n % 3) != 0;
      @(negedge clk);
    end
    n_cmp++;
    if (oe4_err != 0) begin n_bad++; $display("FAIL pwr_oe4 m=%0d bits=%h: %0d wrong clocks, required 0", m, bits, oe4_err); end
    n_cmp++;
    if (hi_err != 0)  begin n_bad++; $display("FAIL pwr_hi m=%0d bits=%h: %0d wrong clocks, required 0", m, bits, hi_err); end
  endtask

  task automatic test_tag_modulation();
    run_mod(3'd2, 8'b1011_0010);
    run_mod(3'd5, 8'h01);
    run_mod(3'd5, 8'hC6);
  endtask

  task automatic test_reader();
    run_mod(3'd4, 8'b1010_0110);
    run_mod(3'd3, 8'hA5);
    run_mod(3'd1, 8'hFF);
  endtask

  task automatic run_subc(input logic [7:0] lo, input logic [7:0] hi, input logic exp);
    int din_err;
    logic e;
    din_err = 0;
    do_reset(3'd3);
    for (int n = 0; n < 48; n++) begin
      e = (n >= 16) ? exp : 1'b0;
      if (ssp_din !== e) din_err++;
      adc = (n % 2 == 1) ? hi : lo;
      @(negedge clk);
    end
    n_cmp++;
    if (din_err != 0) begin
      n_bad++;
      $display("FAIL subc_din lo=%0d hi=%0d: %0d wrong clocks, required 0", lo, hi, din_err);
    end
  endtask

  task automatic test_subcarrier();
    run_subc(8'd0,   8'd200, 1'b1);
    run_subc(8'd100, 8'd120, 1'b0);
    run_subc(8'd0,   8'd41,  1'b1);
    run_subc(8'd0,   8'd40,  1'b0);
  endtask

  task automatic test_reset_mid();
    int err;
    err = 0;
    do_reset(3'd3);
    for (int n = 0; n < 40; n++) begin
      adc = (n % 2 == 1) ? 8'd200 : 8'd0;
      ckb = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if ({ssp_din, ssp_clk, pwr_hi} !== 3'b111) begin
      n_bad++;
      $display("FAIL mid_precondition: got %b required 111", {ssp_din, ssp_clk, pwr_hi});
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ssp_clk, ssp_frame, ssp_din, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg} !== 10'b0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %b required 0000000000",
               {ssp_clk, ssp_frame, ssp_din, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (ssp_clk !== ((n % 16) >= 8)) err++;
      if (ssp_frame !== (n >= 1))      err++;
      if (ssp_din !== 1'b0)            err++;
      adc = (n % 2 == 1) ? 8'd200 : 8'd0;
      @(negedge clk);
    end
    n_cmp++;
    if (err != 0) begin n_bad++; $display("FAIL restart_after_reset: %0d wrong samples, required 0", err); end
  endtask

  initial begin
    rst_n = 1'b0; ckb = 1'b0; adc = 8'd200; mode = 3'd0; dout = 1'b0;
    test_reset();
    test_clocking();
    test_pause_detect();
    test_tag_modulation();
    test_reader();
    test_subcarrier();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
